// File: rtl/if_fetch.sv
// Instruction fetch stage: one-deep buffer feeding IF_ID, single outstanding imem read, branch redirect with drain.
// Optional macro FETCH_TIMEOUT_EN adds an 8-bit wait counter that substitutes a NOP and sets fetch_err on a stuck read.
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_o,
  output logic [31:0] instruction_o,
  output logic        IF_stall,
  output logic        IF_flush,
  output logic        fetch_err
);

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [XLEN-1:0] buf_inst_q, buf_inst_d;
  logic            timeout;

  assign imem_req      = (state_q != FULL);
  assign imem_addr     = req_addr_q;
  assign PC_o          = buf_pc_q;
  assign instruction_o = buf_inst_q;
  assign IF_stall      = (state_q != FULL) || hazard_stall;
  assign IF_flush      = branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= '0;
      req_addr_q <= '0;
      buf_pc_q   <= '0;
      buf_inst_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

  // Next state; a redirect always wins over stall, ack and timeout.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    case (state_q)
      FETCH: begin
        if (branch_taken) begin
          fetch_pc_d = branch_target;
          if (imem_ack) begin
            req_addr_d = branch_target;
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          buf_inst_d = imem_rdata;
          buf_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = FULL;
        end else if (timeout) begin
          buf_inst_d = NOP_INST;
          buf_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = FULL;
        end
      end
      FULL: begin
        if (branch_taken) begin
          fetch_pc_d = branch_target;
          req_addr_d = branch_target;
          state_d    = FETCH;
        end else if (!hazard_stall) begin
          req_addr_d = fetch_pc_q;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        // The stale read must complete before the redirected fetch is issued.
        if (branch_taken) begin
          fetch_pc_d = branch_target;
        end else if (imem_ack || timeout) begin
          req_addr_d = fetch_pc_q;
          state_d    = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] WAIT_MAX = 8'hFF;

  logic [7:0] wait_q, wait_d;
  logic       new_req;
  logic       set_err;
  logic       err_q;

  assign timeout   = (wait_q == WAIT_MAX) && !imem_ack;
  assign fetch_err = err_q;

  // Counter restarts whenever a fresh read (FETCH or DRAIN entry) begins.
  always_comb begin
    new_req = ((state_d != state_q) && (state_d != FULL)) ||
              ((state_q == FETCH) && branch_taken && imem_ack);
    set_err = timeout && !branch_taken && (state_q != FULL);
    wait_d  = wait_q;
    if (new_req) begin
      wait_d = '0;
    end else if (imem_req && !imem_ack) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_q || set_err;
    end
  end
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: transaction-level delivery model checked every cycle plus directed literal checks.
module tb_if_fetch;

`ifdef FETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, hazard_stall, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PC_o, instruction_o;
  logic        IF_stall, IF_flush, fetch_err;

  int checks   = 0;
  int failures = 0;

  if_fetch dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC_o(PC_o), .instruction_o(instruction_o),
    .IF_stall(IF_stall), .IF_flush(IF_flush), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Memory: acks a request once it has waited lat cycles (lat=0 answers in the same cycle).
  int lat = 0;
  int wcnt;
  logic mem_hold;
  always_comb begin
    imem_ack   = imem_req && !mem_hold && (wcnt >= lat);
    imem_rdata = mem_word(imem_addr);
  end
  always_ff @(posedge clk) begin
    if (rst) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Model: m_pc is the next PC to hand to IF_ID; m_buf says it is sitting in the buffer.
  logic [31:0] m_pc, m_inst, m_daddr;
  logic        m_buf, m_drain, m_err;
  int          m_wait;

  always @(negedge clk) begin
    if (rst) begin
      m_pc = 0; m_inst = 0; m_daddr = 0; m_buf = 0; m_drain = 0; m_err = 0; m_wait = 0;
    end else begin
      chk("flush", IF_flush, branch_taken);
      chk("req", imem_req, !m_buf);
      chk("stall", IF_stall, !m_buf || hazard_stall);
      chk("err", fetch_err, m_err);
      if (!m_buf) chk("addr", imem_addr, m_drain ? m_daddr : m_pc);
      if (m_buf) begin
        chk("pc", PC_o, m_pc);
        chk("inst", instruction_o, m_inst);
      end
      if (branch_taken) begin
        if (m_drain) m_wait = imem_ack ? m_wait : m_wait + 1;
        else m_wait = 0;
        if (!m_buf && !m_drain && !imem_ack) begin
          m_drain = 1; m_daddr = m_pc;
        end
        m_pc = branch_target; m_buf = 0;
      end else if (m_drain) begin
        if (imem_ack) begin
          m_drain = 0; m_wait = 0;
        end else if (TO_EN && m_wait == 255) begin
          m_drain = 0; m_err = 1; m_wait = 0;
        end else m_wait++;
      end else if (m_buf) begin
        if (!hazard_stall) begin
          m_buf = 0; m_pc = m_pc + 32'd4; m_wait = 0;
        end
      end else begin
        if (imem_ack) begin
          m_buf = 1; m_inst = mem_word(m_pc);
        end else if (TO_EN && m_wait == 255) begin
          m_buf = 1; m_inst = 32'h0000_0013; m_err = 1;
        end else m_wait++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [23:0] hz;
  int n;

  initial begin
    rst = 1; hazard_stall = 0; branch_taken = 0; branch_target = 0; mem_hold = 0; lat = 0;
    hz = 24'b0000_1100_0000_0110_0001_1000;
    repeat (2) step();
    rst = 0; #1;
    chk("rst_req", imem_req, 1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_stall", IF_stall, 1);
    chk("rst_flush", IF_flush, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_pc", PC_o, 32'h0);
    chk("rst_inst", instruction_o, 32'h0);

    // Zero-wait stream: PC 0,4 delivered every second cycle.
    for (int k = 0; k < 2; k++) begin
      step();
      chk("zw_pc", PC_o, 32'(4 * k));
      chk("zw_inst", instruction_o, mem_word(32'(4 * k)));
      chk("zw_stall", IF_stall, 0);
      step();
      chk("zw_addr", imem_addr, 32'(4 * k + 4));
    end

    // Hazard for 3 cycles with PC 8 buffered.
    step(); hazard_stall = 1; #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      chk("hz_pc", PC_o, 32'h8);
      chk("hz_inst", instruction_o, mem_word(32'h8));
      chk("hz_stall", IF_stall, 1);
      chk("hz_req", imem_req, 0);
    end
    step(); hazard_stall = 0; #1;
    chk("hz_rel_pc", PC_o, 32'h8);
    chk("hz_rel_stall", IF_stall, 0);
    step();
    chk("hz_next_addr", imem_addr, 32'hC);

    // Redirect from FULL at PC 4.
    rst = 1; step(); rst = 0; #1;
    step(); step(); step();
    branch_taken = 1; branch_target = 32'h100; #1;
    chk("br_pc", PC_o, 32'h4);
    chk("br_flush", IF_flush, 1);
    step(); branch_taken = 0; #1;
    chk("br_addr", imem_addr, 32'h100);
    chk("br_flush_off", IF_flush, 0);
    step(); lat = 3; #1;
    chk("br_deliver", PC_o, 32'h100);
    chk("br_deliver_stall", IF_stall, 0);

    // Redirect during a 3-cycle read: old address held until the stale ack.
    step();
    chk("dr_fetch_addr", imem_addr, 32'h104);
    branch_taken = 1; branch_target = 32'h200; #1;
    chk("dr_flush", IF_flush, 1);
    step(); branch_taken = 0; #1;
    chk("dr_hold0", imem_addr, 32'h104);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("dr_hold", imem_addr, 32'h104);
      chk("dr_req", imem_req, 1);
    end
    step();
    chk("dr_new_addr", imem_addr, 32'h200);
    for (int k = 0; k < 8; k++) begin
      step();
      if (!IF_stall) break;
    end
    chk("dr_deliver_stall", IF_stall, 0);
    chk("dr_deliver_pc", PC_o, 32'h200);

    // Reset while draining.
    step(); branch_taken = 1; branch_target = 32'h300; #1;
    step(); branch_taken = 0; rst = 1; #1;
    chk("rd_drain_addr", imem_addr, 32'h204);
    step(); rst = 0; #1;
    chk("rd_addr", imem_addr, 32'h0);
    chk("rd_req", imem_req, 1);
    chk("rd_stall", IF_stall, 1);
    chk("rd_err", fetch_err, 0);

    // Mixed stalls and redirects (one unaligned target) with 1-cycle memory.
    lat = 1;
    for (int i = 0; i < 24; i++) begin
      step();
      hazard_stall  = hz[i];
      branch_taken  = (i == 9) || (i == 17);
      branch_target = (i == 9) ? 32'h1002 : 32'h40;
    end
    step(); hazard_stall = 0; branch_taken = 0;
    repeat (12) step();

`ifdef FETCH_TIMEOUT_EN
    rst = 1; step(); rst = 0; lat = 0; #1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (imem_req && imem_addr == 32'h10) break;
    end
    mem_hold = 1;
    chk("to_start_addr", imem_addr, 32'h10);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      step(); n++;
      if (!IF_stall) break;
    end
    chk("to_cycles", 32'(n), 32'd256);
    chk("to_pc", PC_o, 32'h10);
    chk("to_inst", instruction_o, 32'h0000_0013);
    chk("to_err", fetch_err, 1);
    step();
    chk("to_next_addr", imem_addr, 32'h14);
    chk("to_err_sticky", fetch_err, 1);
    repeat (42) step();
    mem_hold = 0;
    repeat (10) step();
    chk("to_err_still", fetch_err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port hazard_stall, input, 1 bit: ID-stage hazard; the current instruction must be held.
REQ-004 The block SHALL have port branch_taken, input, 1 bit: redirect request, valid for one cycle.
REQ-005 The block SHALL have port branch_target, input, 32 bits: redirect PC, sampled when branch_taken=1.
REQ-006 The block SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-007 The block SHALL have port imem_addr, output, 32 bits: read address; stable while imem_req=1.
REQ-008 The block SHALL have port imem_ack, input, 1 bit: read data valid; only meaningful when imem_req=1.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits: instruction word, valid with imem_ack.
REQ-010 The block SHALL have port PC_o, output, 32 bits: PC of the buffered instruction, to IF_ID PC_i.
REQ-011 The block SHALL have port instruction_o, output, 32 bits: buffered instruction, to IF_ID instruction_i.
REQ-012 The block SHALL have port IF_stall, output, 1 bit: to IF_ID IF_stall.
REQ-013 The block SHALL have port IF_flush, output, 1 bit: to IF_ID IF_flush.
REQ-014 The block SHALL have port fetch_err, output, 1 bit: sticky fetch-timeout flag.

Function
REQ-015 State machine SHALL have states FETCH, FULL and DRAIN; registers fetch_pc, req_addr, buf_pc and buf_inst.
REQ-016 FETCH SHALL drive imem_req=1 and imem_addr=req_addr=fetch_pc; at most one request SHALL be outstanding.
REQ-017 FETCH, imem_ack=1, branch_taken=0 SHALL load buf_inst<=imem_rdata and buf_pc<=fetch_pc, set fetch_pc<=fetch_pc+4 (mod 2^32, wraps to 0), and go to FULL.
REQ-018 FULL SHALL drive imem_req=0; hazard_stall=0 and branch_taken=0 SHALL mark the buffer consumed, load req_addr<=fetch_pc and go to FETCH; hazard_stall=1 SHALL hold FULL with the buffer unchanged.
REQ-019 PC_o=buf_pc and instruction_o=buf_inst SHALL be driven directly from registers; IF_stall SHALL be (state!=FULL) OR hazard_stall.
REQ-020 IF_flush SHALL equal branch_taken combinationally; branch_taken SHALL take priority over hazard_stall and imem_ack.
REQ-021 branch_taken in FULL SHALL discard the buffer, set fetch_pc<=branch_target and req_addr<=branch_target, and go to FETCH.
REQ-022 branch_taken in FETCH with imem_ack=1 the same cycle SHALL discard imem_rdata, set fetch_pc and req_addr to branch_target, and stay in FETCH.
REQ-023 branch_taken in FETCH without imem_ack SHALL set fetch_pc<=branch_target, keep req_addr, and go to DRAIN.
REQ-024 DRAIN SHALL hold imem_req=1 with the old req_addr until imem_ack, then discard the data, load req_addr<=fetch_pc and go to FETCH.
REQ-025 branch_taken in DRAIN SHALL overwrite fetch_pc with the newest branch_target and stay in DRAIN.
REQ-026 branch_target SHALL be used unaligned as given; the block SHALL perform no alignment check.

Reset
REQ-027 rst=1 SHALL set state=FETCH, fetch_pc=req_addr=32'h0, buf_pc=32'h0, buf_inst=32'h0, and fetch_err=0, overriding all other inputs that cycle.
REQ-028 The first cycle after reset deassertion SHALL present imem_req=1, imem_addr=32'h0, IF_stall=1, and IF_flush=branch_taken.
REQ-029 Reset asserted mid-request SHALL abandon the outstanding read; an imem_ack arriving after reset is accepted as the response to the new request at address 0.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN defined SHALL add an 8-bit wait counter that clears on entry to FETCH or DRAIN and increments each cycle imem_req=1 and imem_ack=0.
REQ-031 With FETCH_TIMEOUT_EN defined and the counter reaching 255 in FETCH, the block SHALL load buf_inst<=32'h00000013 and buf_pc<=fetch_pc, set fetch_pc+=4 and fetch_err<=1, and go to FULL.
REQ-032 With FETCH_TIMEOUT_EN defined and the counter reaching 255 in DRAIN, the block SHALL set fetch_err<=1 and go to FETCH.
REQ-033 Without FETCH_TIMEOUT_EN, the block SHALL contain no counter, SHALL tie fetch_err to constant 0, and SHALL wait indefinitely for imem_ack.

Verification
REQ-034 The bench SHALL cover zero-wait memory (ack same cycle as req), no stalls, with response: PC_o sequence 0,4,8,... presented in FULL every 2nd cycle with IF_stall=0, and instruction_o matching memory words.
REQ-035 The bench SHALL cover hazard_stall=1 for 3 cycles while in FULL at PC 8, with response: PC_o=8 and instruction_o held, IF_stall=1, imem_req=0, and the next fetch at address 12 after release.
REQ-036 The bench SHALL cover branch_taken with target 32'h100 while in FULL at PC 4, with response: IF_flush=1 that cycle, the next imem_addr=32'h100, and PC 4 never delivered with IF_stall=0 afterwards.
REQ-037 The bench SHALL cover branch_taken with target 32'h200 in FETCH with memory latency 3 cycles, with response: DRAIN holds imem_addr at the old address until ack, the data is discarded, then imem_addr=32'h200.
REQ-038 The bench SHALL cover rst asserted for 1 cycle while in DRAIN, with response: the next cycle imem_addr=0, state FETCH, and fetch_err=0.
REQ-039 With FETCH_TIMEOUT_EN defined, the bench SHALL cover imem_ack held low for 300 cycles at PC 16, with response: after 255 waiting cycles instruction_o=32'h00000013, PC_o=16, fetch_err=1 (sticky), and the next imem_addr=20.
